instruction_fetch_unit: RTL and testbench

- Fetch stage sitting directly upstream of the LEGv8 main decoder/control unit.
- Holds the PC and fetches 32-bit instructions from instruction memory over a req/ready handshake.
- Presents the fetched instruction, its PC, and the opcode field instruction[31:21] to the decode/control stage.
- Supports decode stall, and branch redirect with squash of any in-flight fetch.

---
 rtl/lego_pkg.sv | 20 ++
 rtl/instruction_fetch_unit_if_id_reg.sv | 40 ++++
 rtl/instruction_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lego_pkg.sv
// Shared definitions for the LEGv8 front end: default widths, fetch FSM encoding,
// PC step and the opcode field position used by the main decoder.
package lego_pkg;

    localparam int DEFAULT_PC_WIDTH    = 64;
    localparam int DEFAULT_INSTR_WIDTH = 32;

    localparam int PC_INCREMENT = 4;

    localparam int OPCODE_MSB   = 31;
    localparam int OPCODE_LSB   = 21;
    localparam int OPCODE_WIDTH = OPCODE_MSB - OPCODE_LSB + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: holds the fetched instruction and its PC for decode.
// clear drops the valid flag and wins over load; contents are zeroed only by reset.
module if_id_reg #(
    parameter int PC_WIDTH    = 64,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic                   i_clear,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic [PC_WIDTH-1:0]    i_pc,
    output logic                   o_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [PC_WIDTH-1:0]    o_pc
);

    logic                   r_valid;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0]    r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// LEGv8 fetch stage: owns the PC, fetches from instruction memory over req/ready,
// and hands instruction, PC and opcode field to decode with stall and branch redirect.
module instruction_fetch_unit
    import lego_pkg::*;
#(
    parameter int                    PC_WIDTH    = DEFAULT_PC_WIDTH,
    parameter int                    INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [PC_WIDTH-1:0]     imem_addr,
    input  logic                    imem_ready,
    input  logic [INSTR_WIDTH-1:0]  imem_rdata,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic [PC_WIDTH-1:0]     branch_target,
    output logic                    instr_valid,
    output logic [INSTR_WIDTH-1:0]  instruction,
    output logic [PC_WIDTH-1:0]     instr_pc,
    output logic [OPCODE_WIDTH-1:0] opcode_field,
    output logic [1:0]              dbg_state
);

    // Memory handshake: a transfer happens in any cycle with imem_req && imem_ready,
    // and imem_rdata belongs to that cycle's imem_addr. Once raised without ready, the
    // request stays up with the same address until ready arrives, even across a
    // redirect (SQUASH) -- it is never withdrawn.

    fetch_state_t          r_state;
    fetch_state_t          w_next_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_addr_q;
    logic                  r_outstanding;

    logic                  w_req;
    logic [PC_WIDTH-1:0]   w_addr;
    logic                  w_xfer;
    logic                  w_load;
    logic                  w_clear;
    logic                  w_valid;
    logic [INSTR_WIDTH-1:0] w_instr;
    logic [PC_WIDTH-1:0]   w_instr_pc;

    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_addr       = r_pc;
        case (r_state)
            IDLE: begin
                w_next_state = FETCH;
            end
            FETCH: begin
                w_req  = !(w_valid && stall);
                w_addr = r_outstanding ? r_addr_q : r_pc;
                if (branch_taken && w_req && !imem_ready) begin
                    w_next_state = SQUASH;
                end
            end
            SQUASH: begin
                w_req  = 1'b1;
                w_addr = r_addr_q;
                if (imem_ready) begin
                    w_next_state = FETCH;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_xfer = w_req && imem_ready;
    // Data returned while squashing, or in a redirect cycle, is never loaded.
    assign w_load  = (r_state == FETCH) && w_xfer && !branch_taken;
    assign w_clear = branch_taken || (w_valid && !stall && !w_load);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_addr_q      <= '0;
            r_outstanding <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (branch_taken) begin
                r_pc <= branch_target;
            end else if (w_load) begin
                r_pc <= w_addr + PC_WIDTH'(PC_INCREMENT);
            end
            if (w_req && !imem_ready) begin
                r_addr_q <= w_addr;
            end
            r_outstanding <= (r_state == FETCH) && w_req && !imem_ready && !branch_taken;
        end
    end

    if_id_reg #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_instr (imem_rdata),
        .i_pc    (w_addr),
        .o_valid (w_valid),
        .o_instr (w_instr),
        .o_pc    (w_instr_pc)
    );

    assign imem_req     = w_req;
    assign imem_addr    = w_addr;
    assign instr_valid  = w_valid;
    assign instruction  = w_instr;
    assign instr_pc     = w_instr_pc;
    assign opcode_field = w_instr[OPCODE_MSB:OPCODE_LSB];
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a memory model answers with an
// address-derived word; monitors pop expected requests and outputs from queues.
module tb_instruction_fetch_unit;
    import lego_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [63:0] instr_pc;
    logic [10:0] opcode_field;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp_req_q[$];
    logic [95:0] exp_out_q[$];

    logic [63:0] mon_req;
    logic [95:0] mon_out;
    logic [31:0] mon_instr;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .PC_WIDTH    (64),
        .INSTR_WIDTH (32),
        .RESET_PC    (64'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instruction   (instruction),
        .instr_pc      (instr_pc),
        .opcode_field  (opcode_field),
        .dbg_state     (dbg_state)
    );

    // Memory contents: word(0)=F8400000 (LDUR, opcode 7C2); opcode bits vary with address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'hF8400000 ^ {a[12:2], 21'h0} ^ a[31:0];
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [63:0] a);
        exp_req_q.push_back(a);
    endtask

    task automatic push_out(input logic [63:0] pc);
        exp_out_q.push_back({pc, mem_word(pc)});
    endtask

    // Request monitor: every transfer outside reset must match the next expected address.
    always @(negedge clk) begin
        if (!rst && imem_req && imem_ready) begin
            if (exp_req_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_request: got addr 0x%0h expected none", imem_addr);
            end else begin
                mon_req = exp_req_q.pop_front();
                check("req_addr", imem_addr, mon_req);
            end
        end
    end

    // Output monitor: an instruction is consumed when valid, not stalled, not redirected.
    always @(negedge clk) begin
        if (!rst && instr_valid && !stall && !branch_taken) begin
            if (exp_out_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got pc 0x%0h expected none", instr_pc);
            end else begin
                mon_out   = exp_out_q.pop_front();
                mon_instr = mon_out[31:0];
                check("out_pc", instr_pc, mon_out[95:32]);
                check("out_instr", {32'h0, instruction}, {32'h0, mon_instr});
                check("out_opcode", {53'h0, opcode_field}, {53'h0, mon_instr[31:21]});
            end
        end
    end

    task automatic drive(input logic r, input logic s, input logic b, input logic [63:0] t);
        imem_ready    = r;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        check("req_q_drained", 64'(exp_req_q.size()), 64'd0);
        check("out_q_drained", 64'(exp_out_q.size()), 64'd0);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instruction, 32'h0);
        check("rst_pc", instr_pc, 64'h0);
        check("rst_opcode", opcode_field, 11'h0);
        check("rst_req", imem_req, 1'b0);
        check("rst_state", dbg_state, IDLE);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 64'h0);

        // Reset, first fetch, streaming at one instruction per cycle
        reset_dut();
        push_req(64'h0); push_req(64'h4); push_req(64'h8); push_req(64'hC);
        push_out(64'h0); push_out(64'h4); push_out(64'h8); push_out(64'hC);
        drive(1'b1, 1'b0, 1'b0, 64'h0);
        check("idle_req", imem_req, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'h0);
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 64'h0);
        check("first_valid_low", instr_valid, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(i < 3, 1'b0, 1'b0, 64'h0);
            check("stream_valid", instr_valid, 1'b1);
            check("stream_pc", instr_pc, 64'(4 * i));
            if (i == 0) check("first_opcode", opcode_field, 11'h7C2);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        check("stream_drain_valid", instr_valid, 1'b0);
        check("stream_hold_addr", imem_addr, 64'h10);
        tick();

        // Wait states at address 8
        reset_dut();
        push_req(64'h0); push_req(64'h4); push_req(64'h8);
        push_out(64'h0); push_out(64'h4); push_out(64'h8);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 64'h0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 64'h0);
            check("wait_req", imem_req, 1'b1);
            check("wait_addr", imem_addr, 64'h8);
            if (i > 0) check("wait_valid", instr_valid, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 64'h0);
        check("wait_done_addr", imem_addr, 64'h8);
        check("wait_done_valid", instr_valid, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        check("wait_cap_valid", instr_valid, 1'b1);
        check("wait_cap_pc", instr_pc, 64'h8);
        check("wait_cap_instr", instruction, 32'hF8000008);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        tick();

        // Decode stall with instruction at pc 4 held
        reset_dut();
        push_req(64'h0); push_req(64'h4); push_req(64'h8);
        push_out(64'h0); push_out(64'h4); push_out(64'h8);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 64'h0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 64'h0);
            check("stall_req", imem_req, 1'b0);
            check("stall_valid", instr_valid, 1'b1);
            check("stall_pc", instr_pc, 64'h4);
            check("stall_instr", instruction, 32'hF8600004);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 64'h0);
        check("unstall_req", imem_req, 1'b1);
        check("unstall_addr", imem_addr, 64'h8);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        check("unstall_next_pc", instr_pc, 64'h8);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        tick();

        // Redirect with a request to 12 in flight; second redirect in SQUASH wins
        reset_dut();
        push_req(64'h0); push_req(64'h4); push_req(64'h8); push_req(64'hC); push_req(64'h100);
        push_out(64'h0); push_out(64'h4); push_out(64'h8); push_out(64'h100);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 64'h0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        check("inflight_addr", imem_addr, 64'hC);
        tick();
        drive(1'b0, 1'b0, 1'b1, 64'h80);
        check("redir_valid", instr_valid, 1'b0);
        check("redir_addr", imem_addr, 64'hC);
        tick();
        drive(1'b0, 1'b0, 1'b1, 64'h100);
        check("squash_state", dbg_state, SQUASH);
        check("squash_req", imem_req, 1'b1);
        check("squash_addr", imem_addr, 64'hC);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'h0);
        check("squash_state2", dbg_state, SQUASH);
        check("squash_addr2", imem_addr, 64'hC);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'h0);
        check("post_squash_state", dbg_state, FETCH);
        check("dropped_valid", instr_valid, 1'b0);
        check("target_addr", imem_addr, 64'h100);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        check("target_valid", instr_valid, 1'b1);
        check("target_pc", instr_pc, 64'h100);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        tick();

        // Transfer + branch + stall together, misaligned target, reset in SQUASH
        reset_dut();
        push_req(64'h0); push_req(64'h42);
        push_out(64'h42);
        drive(1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 64'h42);
        check("simul_req", imem_req, 1'b1);
        check("simul_addr", imem_addr, 64'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'h0);
        check("simul_valid", instr_valid, 1'b0);
        check("simul_state", dbg_state, FETCH);
        check("simul_target_addr", imem_addr, 64'h42);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        check("misalign_pc", instr_pc, 64'h42);
        tick();
        drive(1'b0, 1'b0, 1'b1, 64'h200);
        check("misalign_next_addr", imem_addr, 64'h46);
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 64'h0);
        check("pre_rst_state", dbg_state, SQUASH);
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 64'h0);
        check("rst_sq_state", dbg_state, IDLE);
        check("rst_sq_valid", instr_valid, 1'b0);
        check("rst_sq_req", imem_req, 1'b0);
        push_req(64'h0);
        push_out(64'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'h0);
        check("rst_sq_addr", imem_addr, 64'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        check("rst_sq_out_instr", instruction, 32'hF8400000);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        tick();

        // PC wraps modulo 2^64
        reset_dut();
        push_req(64'h0); push_req(64'hFFFF_FFFF_FFFF_FFFC); push_req(64'h0);
        push_out(64'hFFFF_FFFF_FFFF_FFFC); push_out(64'h0);
        drive(1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'h0);
        check("wrap_top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'h0);
        check("wrap_addr", imem_addr, 64'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        check("wrap_out_pc", instr_pc, 64'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        tick();

        check("final_req_q_drained", 64'(exp_req_q.size()), 64'd0);
        check("final_out_q_drained", 64'(exp_out_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
